// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery multiplier: FSM states, default width
// and the counter sizing helper.
package mont_pkg;

  localparam int DEFAULT_WIDTH = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2
  } state_t;

  // Bit counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/montgomery_mult_if.sv
// Request/response bundle of the Montgomery multiplier: operands with a start
// pulse in, result with a one-cycle done pulse out.
interface montgomery_mult_if
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] result;
  logic             done;

  modport master (
    output start, in_a, in_b, in_m,
    input  result, done
  );

  modport slave (
    input  start, in_a, in_b, in_m,
    output result, done
  );

endinterface

// File: rtl/mont_addsub.sv
// N-bit adder/subtractor; sub=1 yields a - b in two's complement.
module mont_addsub
  import mont_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH + 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  logic [N-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// Define MONT_FINAL_SUB_EN to add the final conditional subtraction (result < M).
module montgomery_mult
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  montgomery_mult_if.slave   bus
);

  localparam int                AW   = WIDTH + 2;
  localparam int                CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] m_reg, m_next;
  logic [AW-1:0]    c_reg, c_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             done_reg, done_next;

  logic             a_bit;
  logic             q;
  logic [AW-1:0]    m_ext;
  logic [AW-1:0]    add0_b, sum0;
  logic [AW-1:0]    add1_a, add1_b, sum1;
  logic             add1_sub;
  logic [WIDTH-1:0] final_val;

  assign a_bit  = a_reg[cnt_reg];
  assign m_ext  = {2'b00, m_reg};
  assign add0_b = a_bit ? {2'b00, b_reg} : '0;

  // Stage 0: C + a_i*B
  mont_addsub #(.N(AW)) u_add0 (
    .a   (c_reg),
    .b   (add0_b),
    .sub (1'b0),
    .sum (sum0)
  );

  // q makes the stage-1 sum even so the shift is an exact divide by two.
  assign q = sum0[0];

`ifdef MONT_FINAL_SUB_EN
  // In SUB the second stage is reused to form C - M; its sign bit is the
  // borrow because a legal C stays below 2M.
  assign add1_a    = (state_reg == SUB) ? c_reg : sum0;
  assign add1_b    = ((state_reg == SUB) || q) ? m_ext : '0;
  assign add1_sub  = (state_reg == SUB);
  assign final_val = sum1[AW-1] ? c_reg[WIDTH-1:0] : sum1[WIDTH-1:0];
`else
  assign add1_a    = sum0;
  assign add1_b    = q ? m_ext : '0;
  assign add1_sub  = 1'b0;
  assign final_val = c_reg[WIDTH-1:0];
`endif

  // Stage 1: (C + a_i*B) + q*M, or C - M in SUB
  mont_addsub #(.N(AW)) u_add1 (
    .a   (add1_a),
    .b   (add1_b),
    .sub (add1_sub),
    .sum (sum1)
  );

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    m_next      = m_reg;
    c_next      = c_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.in_a;
          b_next     = bus.in_b;
          m_next     = bus.in_m;
          c_next     = '0;
          cnt_next   = '0;
          state_next = LOOP;
        end
      end
      LOOP: begin
        c_next   = sum1 >> 1;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          state_next = SUB;
        end
      end
      SUB: begin
        result_next = final_val;
        done_next   = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      m_reg      <= '0;
      c_reg      <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      m_reg      <= m_next;
      c_reg      <= c_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

  assign bus.result = result_reg;
  assign bus.done   = done_reg;

endmodule

// File: doc/montgomery_mult.md
MONTGOMERY_MULT -- requirements
Module: montgomery_mult

Interface
- REQ-001 SHALL have parameter WIDTH, default 1024: operand and modulus width in bits.
- REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
- REQ-004 SHALL have port start, input, 1: request pulse, sampled only in IDLE.
- REQ-005 SHALL have port in_a, input, WIDTH: multiplicand A, sampled with start.
- REQ-006 SHALL have port in_b, input, WIDTH: multiplier B, sampled with start.
- REQ-007 SHALL have port in_m, input, WIDTH: odd modulus M, sampled with start.
- REQ-008 SHALL have port result, output, WIDTH: A*B*2^-WIDTH mod M, held until the next done.
- REQ-009 SHALL have port done, output, 1: one-cycle pulse marking result valid.

Function
- REQ-010 SHALL implement states IDLE, LOOP and SUB, with a registered done.
- REQ-011 SHALL, in IDLE on a clock edge with start=1, latch A, B and M, clear the WIDTH+2-bit accumulator C and the bit counter, and enter LOOP.
- REQ-012 SHALL, on each LOOP edge with counter i, set C <= (C + a_i*B + q*M) >> 1, where q is the LSB of (C + a_i*B); all additions are WIDTH+2 bits with no truncation.
- REQ-013 SHALL increment the counter each LOOP edge and enter SUB after the edge where i=WIDTH-1, i.e. after exactly WIDTH LOOP edges.
- REQ-014 SHALL, at the SUB edge, register result <= (C >= M) ? C-M : C (low WIDTH bits), set done=1 and return to IDLE.
- REQ-015 SHALL assert done exactly WIDTH+1 edges after the edge that sampled start, for exactly one cycle.
- REQ-016 SHALL ignore start in LOOP and SUB; latched operands are unaffected by input changes while busy.
- REQ-017 SHALL accept a new start in the cycle done is high, because the FSM is already in IDLE.
- REQ-018 SHALL keep latency fixed and done asserted even for illegal operands (even M, or A or B >= M); result is then unspecified.

Reset
- REQ-019 SHALL, while reset=1, force state IDLE, done=0, result=0, C=0 and counter=0 immediately, independent of clk.
- REQ-020 SHALL abort any operation in progress when reset asserts mid-LOOP, with no done pulse.
- REQ-021 SHALL accept start on the first clock edge after reset deasserts.

Configuration
- REQ-022 SHALL, when macro MONT_FINAL_SUB_EN is defined, perform the conditional subtraction in SUB, giving 0 <= result < M.
- REQ-023 SHALL, when MONT_FINAL_SUB_EN is undefined, instead set result <= C[WIDTH-1:0] in SUB, giving 0 <= result < 2M, with the same latency.
- REQ-024 SHALL, when MONT_FINAL_SUB_EN is undefined, return a correct result only for M < 2^(WIDTH-1).

Structure
- REQ-025 SHALL place the state enumeration and the default-WIDTH constant in shared package mont_pkg.
- REQ-026 SHALL contain one sub-module, mont_addsub: a WIDTH+2-bit adder/subtractor used for the LOOP addition and the SUB comparison/subtraction.
- REQ-027 SHALL size the counter as clog2(WIDTH) bits.

Verification
- REQ-028 WIDTH=8, A=5, B=7, M=13, start -> done exactly 9 edges after start; result=1.
- REQ-029 WIDTH=8, A=254, B=254, M=255 -> result=1, which exercises the final subtraction at full width (MONT_FINAL_SUB_EN defined).
- REQ-030 WIDTH=1024, A=0, any odd M, B=5 -> result=0, done after 1025 edges.
- REQ-031 WIDTH=1024, A=1, B=R2 mod M, M odd random -> result=R mod M, checked against a software model over 100 random M.
- REQ-032 WIDTH=8, start, then reset pulse at edge 4, then start with A=5, B=7, M=13 -> no done before the second start; done 9 edges after it; result=1.
- REQ-033 WIDTH=8, start held high continuously -> done pulses every 10 cycles; second start while busy ignored; each result matches the first-sampled operands.
